// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID instruction queue.
// Holds the architectural reset PC, the bubble instruction, and the
// fetch-entry record that travels from the SRAM response to the ID stage.
package if_id_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  // One queued fetch: instruction word in the upper half, its PC below.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// Signals:
//   req_ready  - queue has credit for another SRAM request
//   req_fire   - SRAM accepted a request this cycle
//   resp_valid/resp_inst/resp_pc - SRAM returns one instruction
//   flush      - redirect; kills queued and in-flight fetches
//   id_stall   - ID stage cannot take the head this cycle
//   id_valid/id_inst/id_pc - head of queue presented to ID
//   occupancy  - number of queued entries
// Handshake: a request transfers when req_fire=1, which is only legal while
// req_ready=1; an instruction leaves the queue on any cycle where
// id_valid=1, id_stall=0 and flush=0.
// Modport slave is the queue itself, master is the fetch/decode environment.
interface if_id_inst_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              req_ready;
  logic              req_fire;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_inst;
  logic [ADDR_W-1:0] resp_pc;
  logic              flush;
  logic              id_stall;
  logic              id_valid;
  logic [DATA_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    output req_ready, id_valid, id_inst, id_pc, occupancy,
    input  req_fire, resp_valid, resp_inst, resp_pc, flush, id_stall
  );

  modport master (
    input  req_ready, id_valid, id_inst, id_pc, occupancy,
    output req_fire, resp_valid, resp_inst, resp_pc, flush, id_stall
  );

endinterface

// File: rtl/if_id_fifo_mem.sv
// Circular storage for the instruction queue.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (pointers only)
//   wr_en_i      - write wr_data_i at the write pointer and advance it
//   wr_data_i    - packed {inst, pc}
//   rd_en_i      - advance the read pointer
//   clr_i        - empty the storage by moving the read pointer to the
//                  write pointer (wins over rd_en_i)
//   rd_data_o    - entry at the read pointer, read asynchronously
// Occupancy is tracked by the caller; pointers simply wrap modulo DEPTH.
module if_id_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W+ADDR_W-1:0] wr_data_i,
  input  logic                     rd_en_i,
  input  logic                     clr_i,
  output logic [DATA_W+ADDR_W-1:0] rd_data_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (clr_i)        rd_ptr_d = wr_ptr_q;
    else if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read unless the caller's count says so.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_id_inst_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of (instruction, PC) pairs
// between the SRAM-like fetch port and ID, with credit-based request gating
// and discard of stale in-flight responses after a flush.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - handshake bundle (slave side), see if_id_inst_queue_if
// Credit rule: a request may only issue while queued + in-flight < DEPTH,
// so every in-flight response already owns a free slot.
module if_id_inst_queue
  import if_id_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
  input logic               clk,
  input logic               rst,
  if_id_inst_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]   credit_used;
  logic             push, discard, pop;
  logic             head_valid;
  logic [DATA_W+ADDR_W-1:0] head_entry;

  // One extra bit so queued + in-flight (up to 2*DEPTH) cannot wrap.
  assign credit_used   = {1'b0, count_q} + {1'b0, outstanding_q};
  assign bus.req_ready = credit_used < (CNT_W + 1)'(DEPTH);

  assign head_valid = (count_q != '0);
  assign push    = bus.resp_valid && !bus.flush && (drop_cnt_q == '0);
  assign discard = bus.resp_valid && !bus.flush && (drop_cnt_q != '0);
  assign pop     = head_valid && !bus.id_stall && !bus.flush;

  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(bus.req_fire) - CNT_W'(bus.resp_valid);
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    if (bus.flush) begin
      // Everything still in flight, including a request fired this very
      // cycle, belongs to the old stream; a response landing this cycle is
      // already gone, so it is excluded via outstanding_d.
      count_d    = '0;
      drop_cnt_d = outstanding_d;
    end else begin
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (discard) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  if_id_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i ({bus.resp_inst, bus.resp_pc}),
    .rd_en_i   (pop),
    .clr_i     (bus.flush),
    .rd_data_o (head_entry)
  );

  assign bus.id_valid  = head_valid;
  assign bus.id_inst   = head_valid ? head_entry[DATA_W+ADDR_W-1:ADDR_W] : NOP_INST;
  assign bus.id_pc     = head_valid ? head_entry[ADDR_W-1:0] : RESET_PC;
  assign bus.occupancy = count_q;

  // Protocol guards: these can only fire if the fetch unit or SRAM
  // breaks the credit contract.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_push_not_full: assert (!(push && count_q == CNT_W'(DEPTH)));
      a_resp_expected: assert (!(bus.resp_valid && outstanding_q == '0));
      a_fire_w_credit: assert (!(bus.req_fire && !bus.req_ready));
    end
  end

endmodule

// File: tb/tb_if_id_inst_queue.sv
module tb_if_id_inst_queue;
  import if_id_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] B     = 32'hbfc0_0000;

  logic clk;
  logic rst;

  if_id_inst_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

  if_id_inst_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];   // queued {inst, pc} in order, head at index 0
  int          m_out;      // requests in flight
  int          m_drop;     // stale responses still to discard

  typedef struct {
    logic        fire;
    logic        rv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    int          e_occ;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_valid, input logic [31:0] e_inst,
                               input logic [31:0] e_pc, input int e_occ, input logic e_ready);
    chk({tag, ".id_valid"},  32'(bus.id_valid),  32'(e_valid));
    chk({tag, ".id_inst"},   bus.id_inst,        e_inst);
    chk({tag, ".id_pc"},     bus.id_pc,          e_pc);
    chk({tag, ".occupancy"}, 32'(bus.occupancy), 32'(e_occ));
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(e_ready));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic fire, input logic rv, input logic [31:0] inst,
                       input logic [31:0] pc, input logic flush, input logic stall);
    bus.req_fire   = fire;
    bus.resp_valid = rv;
    bus.resp_inst  = inst;
    bus.resp_pc    = pc;
    bus.flush      = flush;
    bus.id_stall   = stall;
  endtask

  task automatic add_vec(input logic fire, input logic rv, input logic [31:0] inst,
                         input logic [31:0] pc, input logic flush, input logic stall,
                         input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc,
                         input int e_occ, input logic e_ready);
    vec_t v;
    v.fire = fire; v.rv = rv; v.inst = inst; v.pc = pc; v.flush = flush; v.stall = stall;
    v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc; v.e_occ = e_occ; v.e_ready = e_ready;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Queue of instructions plus two counters; one call = one clock cycle.
  task automatic model_step(input logic fire, input logic rv, input logic [31:0] inst,
                            input logic [31:0] pc, input logic flush, input logic stall);
    int out_next;
    out_next = m_out + int'(fire) - int'(rv);
    if (flush) begin
      exp_q.delete();
      m_drop = out_next;
    end else begin
      if (exp_q.size() != 0 && !stall) void'(exp_q.pop_front());
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else exp_q.push_back({inst, pc});
      end
    end
    m_out = out_next;
  endtask

  task automatic model_check(input string tag);
    fetch_entry_t head;
    logic         v;
    v = (exp_q.size() != 0);
    head = v ? fetch_entry_t'(exp_q[0]) : '{inst: 32'h0, pc: B};
    check_outputs(tag, v, head.inst, head.pc, exp_q.size(), (exp_q.size() + m_out) < DEPTH);
  endtask

  // ---------------- test ----------------
  initial begin
    logic        fire, rv, flush, stall;
    logic [31:0] inst, pc;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs("reset", 1'b0, 32'h0, B, 0, 1'b1);

    // Directed table: inputs for one cycle, outputs expected the cycle after.
    // single fetch
    add_vec(1, 0, 0, 0, 0, 0,                   0, 0, B, 0, 1);
    add_vec(0, 1, 32'h24010001, B, 0, 0,        1, 32'h24010001, B, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,                   0, 0, B, 0, 1);
    // stall / backpressure
    add_vec(1, 0, 0, 0, 0, 1,                   0, 0, B, 0, 1);
    add_vec(1, 0, 0, 0, 0, 1,                   0, 0, B, 0, 1);
    add_vec(1, 0, 0, 0, 0, 1,                   0, 0, B, 0, 1);
    add_vec(1, 0, 0, 0, 0, 1,                   0, 0, B, 0, 0);
    add_vec(0, 1, 32'h11, B,      0, 1,         1, 32'h11, B, 1, 0);
    add_vec(0, 1, 32'h12, B+4,    0, 1,         1, 32'h11, B, 2, 0);
    add_vec(0, 1, 32'h13, B+8,    0, 1,         1, 32'h11, B, 3, 0);
    add_vec(0, 1, 32'h14, B+12,   0, 1,         1, 32'h11, B, 4, 0);
    add_vec(0, 0, 0, 0, 0, 0,                   1, 32'h12, B+4, 3, 1);
    add_vec(0, 0, 0, 0, 0, 0,                   1, 32'h13, B+8, 2, 1);
    add_vec(0, 0, 0, 0, 0, 0,                   1, 32'h14, B+12, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,                   0, 0, B, 0, 1);
    // flush with two in flight and one queued
    add_vec(1, 0, 0, 0, 0, 1,                   0, 0, B, 0, 1);
    add_vec(1, 1, 32'h21, B+32'h40, 0, 1,       1, 32'h21, B+32'h40, 1, 1);
    add_vec(1, 0, 0, 0, 0, 1,                   1, 32'h21, B+32'h40, 1, 1);
    add_vec(0, 0, 0, 0, 1, 0,                   0, 0, B, 0, 1);
    add_vec(0, 1, 32'h31, B+32'h44, 0, 0,       0, 0, B, 0, 1);
    add_vec(1, 1, 32'h32, B+32'h48, 0, 0,       0, 0, B, 0, 1);
    add_vec(0, 1, 32'h33, B+32'h100, 0, 1,      1, 32'h33, B+32'h100, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,                   0, 0, B, 0, 1);
    // flush coincident with response and new request
    add_vec(1, 0, 0, 0, 0, 0,                   0, 0, B, 0, 1);
    add_vec(1, 1, 32'h41, B+32'h50, 1, 0,       0, 0, B, 0, 1);
    add_vec(0, 1, 32'h42, B+32'h54, 0, 0,       0, 0, B, 0, 1);
    add_vec(1, 0, 0, 0, 0, 0,                   0, 0, B, 0, 1);
    add_vec(0, 1, 32'h43, B+32'h58, 0, 0,       1, 32'h43, B+32'h58, 1, 1);
    add_vec(0, 0, 0, 0, 0, 0,                   0, 0, B, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].fire, vecs[i].rv, vecs[i].inst, vecs[i].pc, vecs[i].flush, vecs[i].stall);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc,
                    vecs[i].e_occ, vecs[i].e_ready);
    end

    // Sustained push + pop: occupancy stays at one, head advances every cycle.
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outputs("thru0", 1'b0, 32'h0, B, 0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      drive(k < 6, 1, 32'h5000 + 32'(k), B + 32'h200 + 32'(4 * (k - 1)), 0, 0);
      @(negedge clk);
      check_outputs($sformatf("thru%0d", k), 1'b1, 32'h5000 + 32'(k),
                    B + 32'h200 + 32'(4 * (k - 1)), 1, 1'b1);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outputs("thru_end", 1'b0, 32'h0, B, 0, 1'b1);

    // Randomised run against the model, with one reset in the middle.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_out  = 0;
    m_drop = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) begin
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_out  = 0;
        m_drop = 0;
        check_outputs("mid_reset", 1'b0, 32'h0, B, 0, 1'b1);
      end
      model_check($sformatf("rand%0d", cyc));
      fire  = ((exp_q.size() + m_out) < DEPTH) && ($urandom_range(0, 99) < 60);
      rv    = (m_out > 0) && ($urandom_range(0, 99) < 55);
      flush = ($urandom_range(0, 99) < 4);
      stall = ($urandom_range(0, 99) < 30);
      inst  = $urandom;
      pc    = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      drive(fire, rv, inst, pc, flush, stall);
      model_step(fire, rv, inst, pc, flush, stall);
      @(negedge clk);
    end
    model_check("rand_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
